// File: rtl/uart_tx_if.sv
// +-----------------------------------------------------------------------------+
// | uart_tx_if : valid/ready word handshake feeding the UART transmitter        |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 ready;

  modport master (output data, output data_valid, input  ready);
  modport slave  (input  data, input  data_valid, output ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// +-----------------------------------------------------------------------------+
// | uart_tx  : UART serial transmitter, start + DATA_BITS + [parity] + stops     |
// | Options  : define UART_TX_PARITY_EN to append an even-parity bit            |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module uart_tx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  uart_tx_if.slave  bus,
  output logic      serial,
  output logic      busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] C_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] C_STOP_LAST = IDX_W'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 busy_q,   busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic bit_end;

  assign bit_end   = (cnt_q == C_CNT_LAST);
  assign bus.ready = (state_q == S_IDLE);
  assign serial    = serial_q;
  assign busy      = busy_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    // serial is registered, so each transition loads the value of the bit that follows
    case (state_q)
      S_IDLE: begin
        idx_d    = '0;
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (bus.data_valid) begin
          shift_d  = bus.data;
          state_d  = S_START;
          serial_d = 1'b0;
          busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = ^bus.data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d  = S_DATA;
          idx_d    = '0;
          serial_d = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == C_DATA_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = S_PARITY;
            serial_d = parity_q;
`else
            state_d  = S_STOP;
            serial_d = 1'b1;
`endif
          end else begin
            idx_d    = idx_q + 1'b1;
            serial_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d  = S_STOP;
          serial_d = 1'b1;
        end
      end
`endif
      S_STOP: begin
        // the bit index is reused to count stop bits
        if (bit_end) begin
          if (idx_q == C_STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
          serial_d = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

`default_nettype wire
